alu_issue: RTL and testbench
============================

Name: alu_issue

Overview:
- Operand-issue stage sitting directly upstream of the NBBPU ALU.
- Accepts 16-bit instructions over a valid/ready handshake and decodes them.
- Reads source operands from an internal 16x16 register file and presents registered X/Y/opcode to the ALU through a one-entry output register.
- Takes ALU results back through a writeback port and tracks pending destinations with a scoreboard to stall RAW/WAW hazards.

Parameters:
- WIDTH, 16, datapath and register width.
- ZERO_REG, 1, when 1 register r0 always reads 0 and writes to it are ignored.

Ports:
- clock  in  1  single clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- instr_valid  in  1  instruction present.
- instr  in  16  fields: [15:12] op, [11:8] x, [7:4] y, [3:0] z (destination).
- instr_ready  out  1  instruction accepted when instr_valid & instr_ready.
- alu_valid  out  1  output register holds an issued operation.
- alu_ready  in  1  ALU/consumer takes the operation when alu_valid & alu_ready.
- alu_X  out  WIDTH  operand X.
- alu_Y  out  WIDTH  operand Y.
- alu_opcode  out  4  ALU opcode.
- alu_z  out  4  destination register carried alongside the operation.
- wb_en  in  1  writeback strobe.
- wb_addr  in  4  writeback register.
- wb_data  in  WIDTH  writeback value.
- illegal_op  out  1  sticky flag, set when an instruction with op[3] = 1 is accepted.

Behaviour:
- **Reset (reset = 0, asynchronous):**
  - All 16 registers, the pending scoreboard, alu_valid, alu_X, alu_Y, alu_opcode, alu_z and illegal_op go to 0.
  - An in-flight operation is discarded.
  - instr_ready is 0 while reset is asserted.
- **Writeback, every cycle:**
  - If wb_en and not (ZERO_REG and wb_addr = 0): reg[wb_addr] <= wb_data, and pending[wb_addr] is cleared.
- **Operand read (combinational, same cycle):**
  - Source value = wb_data when wb_en and wb_addr equals the source (bypass); otherwise reg[src].
  - r0 reads 0 when ZERO_REG = 1, regardless of bypass.
- **Hazard:**
  - A register r is busy if pending[r] = 1 and not (wb_en and wb_addr = r) this cycle.
  - A legal instruction stalls if x, y or z is busy.
  - r0 is never busy when ZERO_REG = 1.
- **instr_ready:**
  - = (not alu_valid or alu_ready) and not stall.
  - Illegal instructions ignore stall and need only output space.
- **Accept of a legal instruction (op[3] = 0):**
  - alu_X, alu_Y, alu_opcode = op, alu_z = z are loaded.
  - alu_valid <= 1.
  - pending[z] <= 1, unless z = 0 with ZERO_REG.
  - If the same cycle's writeback clears the same z, the set wins.
- **Accept of an illegal instruction (op[3] = 1):**
  - Consumed and dropped; no issue, no scoreboard change.
  - illegal_op <= 1 until reset.
- **Output register:**
  - If alu_valid and alu_ready and no new accept: alu_valid <= 0.
  - Operand/opcode values hold their last value when not valid.
  - While alu_valid and not alu_ready, all alu_* outputs hold stable.
- **Throughput and latency:**
  - Back-to-back issue of one op per cycle is possible when there are no hazards and alu_ready = 1.
  - Latency from accept to alu_valid is 1 cycle.
- **Ordering:** operations are issued strictly in program order; no reordering.

Test Plan:
- **Reset and writeback:** release reset; instr_ready = 1, alu_valid = 0, all alu_* = 0. Write r1 = 0x0005 and r2 = 0x0003 via wb, then issue op 0 (x=1, y=2, z=3) -> next cycle alu_valid = 1, X = 0x0005, Y = 0x0003, opcode = 0, alu_z = 3, pending[3] = 1.
- **RAW stall:** issue r3 = r1 + r2, then r4 = r3 - r1 -> second instruction held (instr_ready = 0) until wb_en with addr 3, data 0x0008; in that same cycle it is accepted, with bypass giving X = 0x0008.
- **Backpressure:** hold alu_ready = 0 with alu_valid = 1 -> instr_ready = 0 and all alu_* stable for 5 cycles. Release -> the next queued instruction issues the following cycle with no bubble.
- **r0 and ZERO_REG = 1:**
  - wb addr 0, data 0xFFFF -> r0 still reads 0.
  - Instruction with z = 0 never stalls later readers of r0.
  - Source x = 0 -> X = 0x0000.
- **Illegal op:** instr 0x9123 accepted -> no alu_valid, scoreboard unchanged, illegal_op = 1 and it stays 1 across subsequent legal issues until reset.
- **Reset mid-operation:** assert reset while alu_valid = 1 and pending[5] = 1 -> asynchronously alu_valid = 0, scoreboard clear, r5 = 0. After release, a read of r5 issues without stall.

Source files
------------

// File: rtl/alu_issue.sv
// Operand-issue stage in front of the NBBPU ALU: decodes instructions, reads the
// register file with writeback bypass, stalls on scoreboard hazards, and registers X/Y/opcode.
module alu_issue #(
    parameter int WIDTH    = 16,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             instr_valid,
    input  logic [15:0]      instr,
    output logic             instr_ready,
    output logic             alu_valid,
    input  logic             alu_ready,
    output logic [WIDTH-1:0] alu_X,
    output logic [WIDTH-1:0] alu_Y,
    output logic [3:0]       alu_opcode,
    output logic [3:0]       alu_z,
    input  logic             wb_en,
    input  logic [3:0]       wb_addr,
    input  logic [WIDTH-1:0] wb_data,
    output logic             illegal_op
);

    logic [WIDTH-1:0] regs [16];
    logic [15:0]      pending;
    logic [15:0]      pending_nxt;
    logic [15:0]      wb_hit;
    logic [15:0]      busy;
    logic [15:0]      r0_mask;
    logic [3:0]       op, x, y, z;
    logic [WIDTH-1:0] src_x, src_y;
    logic             legal, space, stall, accept, issue, wb_we;

    assign {op, x, y, z} = instr;
    assign legal   = ~op[3];
    assign r0_mask = ZERO_REG ? 16'h0001 : 16'h0000;
    assign wb_we   = wb_en && !(ZERO_REG && wb_addr == 4'd0);

    always_comb begin
        wb_hit = '0;
        if (wb_en) wb_hit[wb_addr] = 1'b1;
    end

    // A same-cycle writeback retires the hazard, so the reader can go with the bypassed value.
    assign busy = pending & ~wb_hit & ~r0_mask;

    always_comb begin
        src_x = (wb_en && wb_addr == x) ? wb_data : regs[x];
        src_y = (wb_en && wb_addr == y) ? wb_data : regs[y];
        if (ZERO_REG && x == 4'd0) src_x = '0;
        if (ZERO_REG && y == 4'd0) src_y = '0;
    end

    assign space       = ~alu_valid | alu_ready;
    assign stall       = legal && (busy[x] || busy[y] || busy[z]);
    assign instr_ready = reset && space && !stall;
    assign accept      = instr_valid && instr_ready;
    assign issue       = accept && legal;

    // Set after clear: a new producer of z outranks the retiring one.
    always_comb begin
        pending_nxt = pending;
        if (wb_we) pending_nxt[wb_addr] = 1'b0;
        if (issue && !(ZERO_REG && z == 4'd0)) pending_nxt[z] = 1'b1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 16; i++) regs[i] <= '0;
            pending <= '0;
        end else begin
            if (wb_we) regs[wb_addr] <= wb_data;
            pending <= pending_nxt;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            alu_valid  <= 1'b0;
            alu_X      <= '0;
            alu_Y      <= '0;
            alu_opcode <= '0;
            alu_z      <= '0;
            illegal_op <= 1'b0;
        end else begin
            if (issue) begin
                alu_valid  <= 1'b1;
                alu_X      <= src_x;
                alu_Y      <= src_y;
                alu_opcode <= op;
                alu_z      <= z;
            end else if (alu_ready) begin
                alu_valid  <= 1'b0;
            end
            if (accept && !legal) illegal_op <= 1'b1;
        end
    end

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue: directed scenarios plus randomized traffic
// compared against an architectural register/scoreboard model.
module tb_alu_issue;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        instr_valid = 1'b0;
    logic [15:0] instr = '0;
    logic        instr_ready;
    logic        alu_valid;
    logic        alu_ready = 1'b1;
    logic [15:0] alu_X, alu_Y;
    logic [3:0]  alu_opcode, alu_z;
    logic        wb_en = 1'b0;
    logic [3:0]  wb_addr = '0;
    logic [15:0] wb_data = '0;
    logic        illegal_op;

    int tests = 0;
    int fails = 0;

    alu_issue #(.WIDTH(16), .ZERO_REG(1'b1)) dut (
        .clock(clock), .reset(reset),
        .instr_valid(instr_valid), .instr(instr), .instr_ready(instr_ready),
        .alu_valid(alu_valid), .alu_ready(alu_ready),
        .alu_X(alu_X), .alu_Y(alu_Y), .alu_opcode(alu_opcode), .alu_z(alu_z),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .illegal_op(illegal_op)
    );

    always #5 clock = ~clock;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Architectural model: register contents, set of outstanding destinations, issued op.
    logic [15:0] m_reg [16];
    logic        m_pend [16];
    logic        m_valid, m_ill;
    logic [15:0] m_x, m_y;
    logic [3:0]  m_op, m_z;
    logic        exp_ready, obs_ready;

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_reg[i]  = '0;
            m_pend[i] = 1'b0;
        end
        m_valid = 0; m_ill = 0; m_x = 0; m_y = 0; m_op = 0; m_z = 0;
    endtask

    function automatic logic [15:0] m_read(input logic [3:0] r);
        if (r == 0) return 16'h0000;
        if (wb_en && wb_addr == r) return wb_data;
        return m_reg[r];
    endfunction

    function automatic logic m_busy(input logic [3:0] r);
        return (r != 0) && m_pend[r] && !(wb_en && wb_addr == r);
    endfunction

    // Advance one clock with the currently driven inputs, updating the model.
    task automatic tick();
        logic [3:0]  op, x, y, z;
        logic        ill, stall, acc;
        logic [15:0] vx, vy;
        @(negedge clock);
        {op, x, y, z} = instr;
        ill       = op[3];
        stall     = !ill && (m_busy(x) || m_busy(y) || m_busy(z));
        exp_ready = (!m_valid || alu_ready) && !stall;
        obs_ready = instr_ready;
        acc       = instr_valid && exp_ready;
        vx        = m_read(x);
        vy        = m_read(y);
        @(posedge clock);
        if (wb_en && wb_addr != 0) begin
            m_reg[wb_addr]  = wb_data;
            m_pend[wb_addr] = 1'b0;
        end
        if (acc && !ill) begin
            m_valid = 1; m_x = vx; m_y = vy; m_op = op; m_z = z;
            if (z != 0) m_pend[z] = 1'b1;
        end else if (m_valid && alu_ready) begin
            m_valid = 0;
        end
        if (acc && ill) m_ill = 1;
        #1;
    endtask

    task automatic test_reset();
        model_reset();
        #12;
        tests++;
        if (instr_ready !== 1'b0) begin fails++; $display("FAIL reset_ready_low: got %b want 0", instr_ready); end
        @(posedge clock); #1;
        reset = 1'b1;
        #1;
        tests++;
        if (instr_ready !== 1'b1) begin fails++; $display("FAIL release_ready: got %b want 1", instr_ready); end
        tests++;
        if ({alu_valid, alu_X, alu_Y, alu_opcode, alu_z, illegal_op} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: valid=%b X=%h Y=%h op=%h z=%h ill=%b want all 0",
                     alu_valid, alu_X, alu_Y, alu_opcode, alu_z, illegal_op);
        end
    endtask

    task automatic test_basic();
        alu_ready = 1;
        wb_en = 1; wb_addr = 1; wb_data = 16'h0005; tick();
        wb_addr = 2; wb_data = 16'h0003; tick();
        wb_en = 0; instr_valid = 1; instr = 16'h0123; tick();
        instr_valid = 0;
        tests++;
        if (obs_ready !== 1'b1) begin fails++; $display("FAIL basic_accept: ready=%b want 1", obs_ready); end
        tests++;
        if ({alu_valid, alu_X, alu_Y, alu_opcode, alu_z} !== {1'b1, 16'h0005, 16'h0003, 4'h0, 4'h3}) begin
            fails++;
            $display("FAIL basic_issue: valid=%b X=%h Y=%h op=%h z=%h want 1 0005 0003 0 3",
                     alu_valid, alu_X, alu_Y, alu_opcode, alu_z);
        end
    endtask

    task automatic test_raw();
        instr_valid = 1; instr = 16'h1314; alu_ready = 1; wb_en = 0;
        for (int i = 0; i < 2; i++) begin
            tick();
            tests++;
            if (obs_ready !== 1'b0) begin fails++; $display("FAIL raw_stall%0d: ready=%b want 0", i, obs_ready); end
        end
        wb_en = 1; wb_addr = 3; wb_data = 16'h0008; tick();
        tests++;
        if (obs_ready !== 1'b1) begin fails++; $display("FAIL raw_release: ready=%b want 1", obs_ready); end
        wb_en = 0; instr_valid = 0;
        tests++;
        if ({alu_valid, alu_X, alu_Y, alu_opcode, alu_z} !== {1'b1, 16'h0008, 16'h0005, 4'h1, 4'h4}) begin
            fails++;
            $display("FAIL raw_bypass: valid=%b X=%h Y=%h op=%h z=%h want 1 0008 0005 1 4",
                     alu_valid, alu_X, alu_Y, alu_opcode, alu_z);
        end
    endtask

    task automatic test_backpressure();
        wb_en = 1; wb_addr = 4; wb_data = 16'h0003; alu_ready = 1; tick();
        wb_en = 0; instr_valid = 1; instr = 16'h2125; alu_ready = 0; tick();
        instr = 16'h3126;
        for (int i = 0; i < 5; i++) begin
            tick();
            tests++;
            if (obs_ready !== 1'b0 ||
                {alu_valid, alu_X, alu_Y, alu_opcode, alu_z} !== {1'b1, 16'h0005, 16'h0003, 4'h2, 4'h5}) begin
                fails++;
                $display("FAIL bp_hold%0d: ready=%b valid=%b X=%h Y=%h op=%h z=%h want 0 1 0005 0003 2 5",
                         i, obs_ready, alu_valid, alu_X, alu_Y, alu_opcode, alu_z);
            end
        end
        alu_ready = 1; tick();
        instr_valid = 0;
        tests++;
        if (obs_ready !== 1'b1 || {alu_valid, alu_opcode, alu_z} !== {1'b1, 4'h3, 4'h6}) begin
            fails++;
            $display("FAIL bp_release: ready=%b valid=%b op=%h z=%h want 1 1 3 6",
                     obs_ready, alu_valid, alu_opcode, alu_z);
        end
    endtask

    task automatic test_r0();
        alu_ready = 1; instr_valid = 1; instr = 16'h4002;
        wb_en = 1; wb_addr = 0; wb_data = 16'hFFFF; tick();
        wb_en = 0;
        tests++;
        if (alu_X !== 16'h0000 || alu_Y !== 16'h0000) begin
            fails++; $display("FAIL r0_bypass: X=%h Y=%h want 0000 0000", alu_X, alu_Y);
        end
        instr = 16'h5110; tick();
        instr = 16'h6010; tick();
        instr_valid = 0;
        tests++;
        if (obs_ready !== 1'b1 || alu_opcode !== 4'h6 || alu_X !== 16'h0000) begin
            fails++;
            $display("FAIL r0_nostall: ready=%b op=%h X=%h want 1 6 0000", obs_ready, alu_opcode, alu_X);
        end
    endtask

    task automatic test_illegal();
        alu_ready = 1; instr_valid = 0; tick();
        instr_valid = 1; instr = 16'h9123; tick();
        instr_valid = 0;
        tests++;
        if (obs_ready !== 1'b1 || alu_valid !== 1'b0 || illegal_op !== 1'b1) begin
            fails++;
            $display("FAIL illegal_drop: ready=%b valid=%b ill=%b want 1 0 1", obs_ready, alu_valid, illegal_op);
        end
        instr_valid = 1; instr = 16'h0300; tick();
        instr_valid = 0;
        tests++;
        if (obs_ready !== 1'b1 || alu_valid !== 1'b1 || alu_X !== 16'h0008 || illegal_op !== 1'b1) begin
            fails++;
            $display("FAIL illegal_sticky: ready=%b valid=%b X=%h ill=%b want 1 1 0008 1",
                     obs_ready, alu_valid, alu_X, illegal_op);
        end
    endtask

    task automatic test_reset_mid();
        alu_ready = 1; wb_en = 1; wb_addr = 5; wb_data = 16'h1234; tick();
        wb_en = 0; instr_valid = 1; instr = 16'h7015; alu_ready = 0; tick();
        instr_valid = 0;
        #2 reset = 1'b0;
        #1;
        model_reset();
        tests++;
        if (alu_valid !== 1'b0 || alu_X !== 16'h0000 || illegal_op !== 1'b0 || instr_ready !== 1'b0) begin
            fails++;
            $display("FAIL reset_async: valid=%b X=%h ill=%b ready=%b want 0 0000 0 0",
                     alu_valid, alu_X, illegal_op, instr_ready);
        end
        @(posedge clock); #1;
        reset = 1'b1;
        alu_ready = 1; instr_valid = 1; instr = 16'h0505; tick();
        instr_valid = 0;
        tests++;
        if (obs_ready !== 1'b1 || alu_valid !== 1'b1 || alu_X !== 16'h0000) begin
            fails++;
            $display("FAIL reset_sb_clear: ready=%b valid=%b X=%h want 1 1 0000", obs_ready, alu_valid, alu_X);
        end
    endtask

    task automatic test_random();
        int pend_q[$];
        for (int n = 0; n < 600; n++) begin
            logic [3:0] op;
            op = ($urandom_range(0, 9) == 0) ? 4'(8 + $urandom_range(0, 7)) : 4'($urandom_range(0, 7));
            instr_valid = ($urandom_range(0, 3) != 0);
            instr       = {op, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15))};
            alu_ready   = ($urandom_range(0, 3) != 0);
            wb_en       = ($urandom_range(0, 2) == 0);
            wb_data     = 16'($urandom);
            pend_q.delete();
            for (int r = 0; r < 16; r++) if (m_pend[r]) pend_q.push_back(r);
            if (pend_q.size() > 0 && $urandom_range(0, 9) < 7)
                wb_addr = 4'(pend_q[$urandom_range(0, pend_q.size() - 1)]);
            else
                wb_addr = 4'($urandom_range(0, 15));
            tick();
            tests++;
            if (obs_ready !== exp_ready) begin
                fails++; $display("FAIL rnd_ready cyc%0d: got %b want %b", n, obs_ready, exp_ready);
            end
            tests++;
            if ({alu_valid, alu_X, alu_Y, alu_opcode, alu_z, illegal_op} !== {m_valid, m_x, m_y, m_op, m_z, m_ill}) begin
                fails++;
                $display("FAIL rnd_out cyc%0d: valid=%b X=%h Y=%h op=%h z=%h ill=%b want %b %h %h %h %h %b",
                         n, alu_valid, alu_X, alu_Y, alu_opcode, alu_z, illegal_op,
                         m_valid, m_x, m_y, m_op, m_z, m_ill);
            end
        end
        instr_valid = 0; wb_en = 0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_raw();
        test_backpressure();
        test_r0();
        test_illegal();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
